// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle of the branch resolution unit: operands and prediction in, resolved control transfer out.
// The statistics counters are present only when BRANCH_RESOLVE_STATS_EN is defined.
`timescale 1ns/1ps
interface branch_resolve_unit_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
`ifdef BRANCH_RESOLVE_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [6:0]        opcode_i;
  logic [2:0]        funct3_i;
  logic [AWIDTH-1:0] pc_i;
  logic [DWIDTH-1:0] imm_i;
  logic [DWIDTH-1:0] rs1_i;
  logic [DWIDTH-1:0] rs2_i;
  logic              pred_taken_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              breq_o;
  logic              brlt_o;
  logic              brltu_o;
  logic              taken_o;
  logic [AWIDTH-1:0] target_o;
  logic [AWIDTH-1:0] redirect_pc_o;
  logic              mispredict_o;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [CNT_WIDTH-1:0] branch_cnt_o;
  logic [CNT_WIDTH-1:0] mispredict_cnt_o;
`endif

  // Requester side: issues requests and consumes results.
  modport master (
    output in_valid_i, opcode_i, funct3_i, pc_i, imm_i, rs1_i, rs2_i, pred_taken_i, out_ready_i,
    input  in_ready_o, out_valid_o, breq_o, brlt_o, brltu_o, taken_o, target_o, redirect_pc_o,
`ifdef BRANCH_RESOLVE_STATS_EN
           branch_cnt_o, mispredict_cnt_o,
`endif
           mispredict_o
  );

  modport slave (
    input  in_valid_i, opcode_i, funct3_i, pc_i, imm_i, rs1_i, rs2_i, pred_taken_i, out_ready_i,
    output in_ready_o, out_valid_o, breq_o, brlt_o, brltu_o, taken_o, target_o, redirect_pc_o,
`ifdef BRANCH_RESOLVE_STATS_EN
           branch_cnt_o, mispredict_cnt_o,
`endif
           mispredict_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// RV32I branch/jump resolution with one registered valid/ready output stage and misprediction detection.
// Define BRANCH_RESOLVE_STATS_EN to add saturating branch and mispredict counters.
`timescale 1ns/1ps
module branch_resolve_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
`ifdef BRANCH_RESOLVE_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input logic                  clk,
  input logic                  reset,
  branch_resolve_unit_if.slave bus
);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef struct packed {
    logic              breq;
    logic              brlt;
    logic              brltu;
    logic              taken;
    logic [AWIDTH-1:0] target;
    logic [AWIDTH-1:0] redirect;
    logic              mispredict;
  } result_t;

  result_t           result_d, result_q;
  logic              out_valid_q;
  logic              accept;
  logic [DWIDTH-1:0] rs1_imm;
  logic [AWIDTH-1:0] pc_imm;
  logic [AWIDTH-1:0] jalr_target;

  assign bus.in_ready_o = !out_valid_q || bus.out_ready_i;
  assign accept         = bus.in_valid_i && bus.in_ready_o;

  assign rs1_imm     = bus.rs1_i + bus.imm_i;
  assign pc_imm      = bus.pc_i + bus.imm_i[AWIDTH-1:0];
  assign jalr_target = {rs1_imm[AWIDTH-1:1], 1'b0};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    result_d        = '0;
    result_d.breq   = (bus.rs1_i == bus.rs2_i);
    result_d.brlt   = ($signed(bus.rs1_i) < $signed(bus.rs2_i));
    result_d.brltu  = (bus.rs1_i < bus.rs2_i);
    result_d.target = pc_imm;
    unique case (bus.opcode_i)
      OP_BRANCH: begin
        case (bus.funct3_i)
          F3_BEQ:  result_d.taken = result_d.breq;
          F3_BNE:  result_d.taken = !result_d.breq;
          F3_BLT:  result_d.taken = result_d.brlt;
          F3_BGE:  result_d.taken = !result_d.brlt;
          F3_BLTU: result_d.taken = result_d.brltu;
          F3_BGEU: result_d.taken = !result_d.brltu;
          default: result_d.taken = 1'b0;
        endcase
      end
      OP_JAL:  result_d.taken = 1'b1;
      OP_JALR: begin
        result_d.taken  = 1'b1;
        result_d.target = jalr_target;
      end
      default: result_d.taken = 1'b0;
    endcase
    result_d.redirect   = result_d.taken ? result_d.target : bus.pc_i + AWIDTH'(4);
    result_d.mispredict = result_d.taken ^ bus.pred_taken_i;
  end

  // A consume without a new accept only drops valid; the result fields keep their last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
      out_valid_q <= 1'b1;
      result_q    <= result_d;
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid_o   = out_valid_q;
  assign bus.breq_o        = result_q.breq;
  assign bus.brlt_o        = result_q.brlt;
  assign bus.brltu_o       = result_q.brltu;
  assign bus.taken_o       = result_q.taken;
  assign bus.target_o      = result_q.target;
  assign bus.redirect_pc_o = result_q.redirect;
  assign bus.mispredict_o  = result_q.mispredict;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic                 is_ctrl_q;
  logic                 consume;
  logic [CNT_WIDTH-1:0] branch_cnt_q;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q;

  assign consume = out_valid_q && bus.out_ready_i;

  // Counters advance when a result leaves the stage, not when it is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_ctrl_q        <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (accept) begin
        is_ctrl_q <= (bus.opcode_i == OP_BRANCH) || (bus.opcode_i == OP_JAL) ||
                     (bus.opcode_i == OP_JALR);
      end
      if (consume && is_ctrl_q && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + 1'b1;
      end
      if (consume && result_q.mispredict && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
      end
    end
  end

  assign bus.branch_cnt_o     = branch_cnt_q;
  assign bus.mispredict_cnt_o = mispredict_cnt_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference model pushes expected results at accept, popped at consume.
// Also exercises the BRANCH_RESOLVE_STATS_EN counters when that macro is defined.
`timescale 1ns/1ps
module tb_branch_resolve_unit;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [6:0]    op;
    logic [2:0]    f3;
    logic [AW-1:0] pc;
    logic [DW-1:0] imm;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic          pred;
  } req_t;

  typedef struct packed {
    logic          breq;
    logic          brlt;
    logic          brltu;
    logic          taken;
    logic [AW-1:0] target;
    logic [AW-1:0] redirect;
    logic          mispredict;
  } res_t;

  typedef struct {
    res_t r;
    logic is_ctrl;
  } entry_t;

  logic   clk = 1'b0;
  logic   reset;
  entry_t sb[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     exp_bcnt = 0;
  int     exp_mcnt = 0;
  logic [6:0] rand_ops [6];

  always #5 clk = ~clk;

  branch_resolve_unit_if #(
    .DWIDTH(DW), .AWIDTH(AW)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) bus ();

  branch_resolve_unit #(
    .DWIDTH(DW), .AWIDTH(AW)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic req_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic pred);
    req_t r;
    r.op = op; r.f3 = f3; r.pc = pc; r.imm = imm; r.rs1 = rs1; r.rs2 = rs2; r.pred = pred;
    return r;
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  // Reference behaviour of one request, written straight from the RV32I branch/jump rules.
  function automatic res_t model(input req_t r);
    res_t          e;
    logic [DW-1:0] s;
    logic [AW-1:0] jt;
    e        = '0;
    e.breq   = (r.rs1 == r.rs2);
    e.brlt   = ($signed(r.rs1) < $signed(r.rs2));
    e.brltu  = (r.rs1 < r.rs2);
    e.target = r.pc + r.imm[AW-1:0];
    if (r.op == OP_BRANCH) begin
      case (r.f3)
        3'b000:  e.taken = e.breq;
        3'b001:  e.taken = !e.breq;
        3'b100:  e.taken = e.brlt;
        3'b101:  e.taken = !e.brlt;
        3'b110:  e.taken = e.brltu;
        3'b111:  e.taken = !e.brltu;
        default: e.taken = 1'b0;
      endcase
    end else if (r.op == OP_JAL) begin
      e.taken = 1'b1;
    end else if (r.op == OP_JALR) begin
      s        = r.rs1 + r.imm;
      jt       = s[AW-1:0];
      jt[0]    = 1'b0;
      e.target = jt;
      e.taken  = 1'b1;
    end
    e.redirect   = e.taken ? e.target : r.pc + AW'(4);
    e.mispredict = e.taken ^ r.pred;
    return e;
  endfunction

  function automatic res_t obs();
    return {bus.breq_o, bus.brlt_o, bus.brltu_o, bus.taken_o, bus.target_o,
            bus.redirect_pc_o, bus.mispredict_o};
  endfunction

  // One clock of stimulus: drive at the falling edge, check protocol and scoreboard 1 ns later.
  task automatic cycle(input logic v, input req_t r, input logic rdy, input string tag);
    logic   held;
    logic   acc;
    entry_t e;
    res_t   o;
    @(negedge clk);
    bus.in_valid_i   = v;
    bus.opcode_i     = r.op;
    bus.funct3_i     = r.f3;
    bus.pc_i         = r.pc;
    bus.imm_i        = r.imm;
    bus.rs1_i        = r.rs1;
    bus.rs2_i        = r.rs2;
    bus.pred_taken_i = r.pred;
    bus.out_ready_i  = rdy;
    #1;
    held = (sb.size() != 0);
    acc  = v && (!held || rdy);
    n_cmp++;
    if (bus.out_valid_o !== held) begin
      n_err++;
      $display("FAIL %s out_valid: got %b want %b", tag, bus.out_valid_o, held);
    end
    n_cmp++;
    if (bus.in_ready_o !== (!held || rdy)) begin
      n_err++;
      $display("FAIL %s in_ready: got %b want %b", tag, bus.in_ready_o, !held || rdy);
    end
`ifdef BRANCH_RESOLVE_STATS_EN
    n_cmp++;
    if (bus.branch_cnt_o !== CW'(exp_bcnt) || bus.mispredict_cnt_o !== CW'(exp_mcnt)) begin
      n_err++;
      $display("FAIL %s counters: got %0d/%0d want %0d/%0d", tag, bus.branch_cnt_o,
               bus.mispredict_cnt_o, exp_bcnt, exp_mcnt);
    end
`endif
    if (held && rdy) begin
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e.r) begin
        n_err++;
        $display("FAIL %s result: got %h want %h", tag, o, e.r);
      end
      if (e.is_ctrl && exp_bcnt < MAXC) exp_bcnt++;
      if (e.r.mispredict && exp_mcnt < MAXC) exp_mcnt++;
    end
    if (acc) sb.push_back('{r: model(r), is_ctrl: is_ctrl(r.op)});
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, '0, 1'b1, "drain");
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if (bus.out_valid_o !== 1'b0 || obs() !== '0) begin
      n_err++;
      $display("FAIL %s reset outputs: got valid %b result %h want 0", tag, bus.out_valid_o, obs());
    end
`ifdef BRANCH_RESOLVE_STATS_EN
    n_cmp++;
    if (bus.branch_cnt_o !== '0 || bus.mispredict_cnt_o !== '0) begin
      n_err++;
      $display("FAIL %s reset counters: got %0d/%0d want 0/0", tag, bus.branch_cnt_o, bus.mispredict_cnt_o);
    end
`endif
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset_held");
    n_cmp++;
    if (bus.in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_held in_ready: got %b want 1", bus.in_ready_o);
    end
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, '0, 1'b0, "reset_released");
    check_zero("reset_released");
  endtask

  task automatic test_async_reset();
    cycle(1'b1, mk(OP_JAL, 3'b000, 32'h200, 32'h40, 32'h0, 32'h0, 1'b0), 1'b0, "async_load");
    cycle(1'b0, '0, 1'b0, "async_held");
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    sb.delete();
    exp_bcnt = 0;
    exp_mcnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_branch_compare();
    cycle(1'b1, mk(OP_BRANCH, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0), 1'b0, "blt");
    cycle(1'b0, '0, 1'b0, "blt_hold");
    n_cmp++;
    if ({bus.brlt_o, bus.brltu_o, bus.taken_o, bus.target_o, bus.redirect_pc_o, bus.mispredict_o} !==
        {1'b1, 1'b0, 1'b1, 32'h120, 32'h120, 1'b1}) begin
      n_err++;
      $display("FAIL blt fields: got %h want brlt=1 brltu=0 taken=1 target=120 redirect=120 mispredict=1", obs());
    end
    cycle(1'b1, mk(OP_BRANCH, 3'b111, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0), 1'b1, "bgeu");
    cycle(1'b0, '0, 1'b0, "bgeu_hold");
    n_cmp++;
    if (bus.taken_o !== 1'b1) begin
      n_err++;
      $display("FAIL bgeu taken: got %b want 1", bus.taken_o);
    end
    cycle(1'b1, mk(OP_BRANCH, 3'b001, 32'h300, 32'hFFFF_FFF0, 32'h7, 32'h7, 1'b1), 1'b1, "bne");
    cycle(1'b1, mk(OP_BRANCH, 3'b101, 32'h304, 32'h10, 32'h8000_0000, 32'h1, 1'b1), 1'b1, "bge");
    cycle(1'b1, mk(OP_BRANCH, 3'b110, 32'h308, 32'h8, 32'h1, 32'h8000_0000, 1'b1), 1'b1, "bltu");
    drain();
  endtask

  task automatic test_jumps();
    cycle(1'b1, mk(OP_JALR, 3'b000, 32'h500, 32'h4, 32'h1003, 32'h0, 1'b1), 1'b1, "jalr");
    cycle(1'b0, '0, 1'b0, "jalr_hold");
    n_cmp++;
    if ({bus.taken_o, bus.target_o, bus.mispredict_o} !== {1'b1, 32'h1006, 1'b0}) begin
      n_err++;
      $display("FAIL jalr fields: got taken=%b target=%h mispredict=%b want 1/1006/0",
               bus.taken_o, bus.target_o, bus.mispredict_o);
    end
    cycle(1'b1, mk(OP_BRANCH, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h5, 32'h5, 1'b1), 1'b1, "beq_wrap");
    cycle(1'b0, '0, 1'b0, "beq_wrap_hold");
    n_cmp++;
    if ({bus.taken_o, bus.target_o, bus.redirect_pc_o} !== {1'b1, 32'h4, 32'h4}) begin
      n_err++;
      $display("FAIL beq_wrap fields: got taken=%b target=%h redirect=%h want 1/4/4",
               bus.taken_o, bus.target_o, bus.redirect_pc_o);
    end
    cycle(1'b1, mk(OP_JAL, 3'b000, 32'h800, 32'hFFFF_F000, 32'h0, 32'h0, 1'b0), 1'b1, "jal");
    drain();
  endtask

  task automatic test_nonbranch();
    cycle(1'b1, mk(OP_REG, 3'b000, 32'h40, 32'h100, 32'h1, 32'h2, 1'b1), 1'b1, "nonbranch");
    cycle(1'b0, '0, 1'b0, "nonbranch_hold");
    n_cmp++;
    if ({bus.taken_o, bus.redirect_pc_o, bus.mispredict_o} !== {1'b0, 32'h44, 1'b1}) begin
      n_err++;
      $display("FAIL nonbranch fields: got taken=%b redirect=%h mispredict=%b want 0/44/1",
               bus.taken_o, bus.redirect_pc_o, bus.mispredict_o);
    end
    cycle(1'b1, mk(OP_BRANCH, 3'b010, 32'h60, 32'h20, 32'h3, 32'h3, 1'b0), 1'b1, "f3_010");
    cycle(1'b0, '0, 1'b0, "f3_010_hold");
    n_cmp++;
    if ({bus.taken_o, bus.redirect_pc_o} !== {1'b0, 32'h64}) begin
      n_err++;
      $display("FAIL f3_010 fields: got taken=%b redirect=%h want 0/64", bus.taken_o, bus.redirect_pc_o);
    end
    cycle(1'b1, mk(OP_BRANCH, 3'b011, 32'h70, 32'h20, 32'h3, 32'h9, 1'b1), 1'b1, "f3_011");
    drain();
  endtask

  task automatic test_back_to_back();
    res_t snap;
    snap = '0;
    cycle(1'b1, mk(OP_BRANCH, 3'b000, 32'h1000, 32'h10, 32'h9, 32'h9, 1'b0), 1'b1, "bp_a");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, mk(OP_BRANCH, 3'b001, 32'h1004, 32'h10, 32'h9, 32'h9, 1'b0), 1'b0, "bp_stall");
      if (i == 0) snap = obs();
      else begin
        n_cmp++;
        if (obs() !== snap) begin
          n_err++;
          $display("FAIL bp_stable: got %h want %h", obs(), snap);
        end
      end
    end
    cycle(1'b1, mk(OP_BRANCH, 3'b001, 32'h1004, 32'h10, 32'h9, 32'h9, 1'b0), 1'b1, "bp_b");
    cycle(1'b1, mk(OP_JALR, 3'b000, 32'h1008, 32'h7, 32'h2000, 32'h0, 1'b1), 1'b1, "bp_c");
    cycle(1'b1, mk(OP_REG, 3'b000, 32'h100C, 32'h0, 32'h0, 32'h0, 1'b0), 1'b1, "bp_d");
    drain();
  endtask

  task automatic test_random();
    req_t r;
    for (int i = 0; i < 120; i++) begin
      r.op   = rand_ops[$urandom_range(0, 5)];
      r.f3   = 3'($urandom_range(0, 7));
      r.pc   = $urandom;
      r.imm  = $urandom;
      r.rs1  = $urandom;
      r.rs2  = ($urandom_range(0, 3) == 0) ? r.rs1 : $urandom;
      r.pred = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 9) < 7), "random");
    end
    drain();
  endtask

`ifdef BRANCH_RESOLVE_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid_i = 1'b0;
    sb.delete();
    exp_bcnt = 0;
    exp_mcnt = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, mk(OP_BRANCH, 3'b100, 32'h40 + 32'(i * 4), 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0),
            1'b1, "stats_blt");
    end
    drain();
    n_cmp++;
    if (bus.branch_cnt_o !== 2'd3 || bus.mispredict_cnt_o !== 2'd3) begin
      n_err++;
      $display("FAIL stats_saturate: got %0d/%0d want 3/3", bus.branch_cnt_o, bus.mispredict_cnt_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rand_ops = '{OP_BRANCH, OP_BRANCH, OP_BRANCH, OP_JAL, OP_JALR, OP_REG};
    reset            = 1'b1;
    bus.in_valid_i   = 1'b0;
    bus.opcode_i     = '0;
    bus.funct3_i     = '0;
    bus.pc_i         = '0;
    bus.imm_i        = '0;
    bus.rs1_i        = '0;
    bus.rs2_i        = '0;
    bus.pred_taken_i = 1'b0;
    bus.out_ready_i  = 1'b0;
    test_reset();
    test_async_reset();
    test_branch_compare();
    test_jumps();
    test_nonbranch();
    test_back_to_back();
    test_random();
`ifdef BRANCH_RESOLVE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
